// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//   Pipeline register between instruction decode and execute. It accepts one
//   decoded instruction per cycle over a valid/ready handshake and resolves
//   the two ALU operands (register value, forwarded value, PC or immediate).
//   It then presents them, registered, to the ALU over a second valid/ready
//   handshake. It also keeps a saturating count of back-pressure cycles.
//
// Configuration macro:
//   ID_EX_FORWARD_EN  defined   -> register operands are bypassed from the MEM
//                                  and WB writeback ports (MEM wins, x0 never
//                                  forwards).
//                     undefined -> register operands come straight from
//                                  in_rs1_data / in_rs2_data; the fwd_* ports
//                                  remain on the interface but are ignored.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             decode-side handshake
//   in_pc, in_rs1_data,
//   in_rs2_data, in_imm             32-bit decoded fields
//   in_rs1_addr, in_rs2_addr,
//   in_rd_addr                      5-bit register indices
//   in_alu_op                       4-bit ALU opcode (EXE_*_OP encoding)
//   in_src1_pc, in_src2_imm         operand source selects
//   fwd_mem_wen/rd/data             MEM-stage writeback bypass source
//   fwd_wb_wen/rd/data              WB-stage writeback bypass source
//   flush                           kill held and incoming instruction
//   out_valid / out_ready           ALU-side handshake
//   operand1, operand2              registered ALU operands
//   opcode                          registered ALU opcode
//   out_rd_addr                     registered destination index
//   stall_cnt                       saturating out_valid && !out_ready count
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [4:0]  in_rd_addr,
    input  logic [3:0]  in_alu_op,
    input  logic        in_src1_pc,
    input  logic        in_src2_imm,

    input  logic        fwd_mem_wen,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_mem_data,
    input  logic        fwd_wb_wen,
    input  logic [4:0]  fwd_wb_rd,
    input  logic [31:0] fwd_wb_data,

    input  logic        flush,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [3:0]  opcode,
    output logic [4:0]  out_rd_addr,
    output logic [15:0] stall_cnt
);

    // Opcode the stage resets to, so an idle ALU sees a harmless add.
    localparam logic [3:0]  EXE_ADD_OP = 4'b0000;
    localparam logic [15:0] STALL_MAX  = 16'hFFFF;

    // Registered state and next-state values.
    logic        out_valid_q, out_valid_d;
    logic [31:0] operand1_q,  operand1_d;
    logic [31:0] operand2_q,  operand2_d;
    logic [3:0]  opcode_q;
    logic [4:0]  rd_addr_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        capture;
    logic        stalled;
    logic [31:0] rs1Fwd;
    logic [31:0] rs2Fwd;

    // The stage can take a new instruction whenever its slot is empty or the
    // current occupant leaves this cycle. flush deliberately does not gate
    // ready; it only suppresses the capture.
    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign stalled  = out_valid_q && !out_ready;

`ifdef ID_EX_FORWARD_EN
    // Bypass network: the MEM stage holds the younger result, so it is tested
    // before WB. Register x0 is hard-wired zero and must never pick up a
    // forwarded value even if a stage claims to write it.
    always_comb begin
        rs1Fwd = in_rs1_data;
        if (in_rs1_addr != 5'd0) begin
            if (fwd_mem_wen && (fwd_mem_rd == in_rs1_addr)) begin
                rs1Fwd = fwd_mem_data;
            end else if (fwd_wb_wen && (fwd_wb_rd == in_rs1_addr)) begin
                rs1Fwd = fwd_wb_data;
            end
        end
    end

    always_comb begin
        rs2Fwd = in_rs2_data;
        if (in_rs2_addr != 5'd0) begin
            if (fwd_mem_wen && (fwd_mem_rd == in_rs2_addr)) begin
                rs2Fwd = fwd_mem_data;
            end else if (fwd_wb_wen && (fwd_wb_rd == in_rs2_addr)) begin
                rs2Fwd = fwd_wb_data;
            end
        end
    end
`else
    // Without bypassing the register file values are used directly; the
    // forwarding ports and source indices are folded into a sink so the
    // interface stays identical between builds.
    assign rs1Fwd = in_rs1_data;
    assign rs2Fwd = in_rs2_data;

    logic unusedFwd;
    assign unusedFwd = ^{in_rs1_addr, in_rs2_addr,
                         fwd_mem_wen, fwd_mem_rd, fwd_mem_data,
                         fwd_wb_wen,  fwd_wb_rd,  fwd_wb_data};
`endif

    // Operand source selection for the instruction being captured.
    assign operand1_d = in_src1_pc  ? in_pc  : rs1Fwd;
    assign operand2_d = in_src2_imm ? in_imm : rs2Fwd;

    // Occupancy: flush wins over everything, a capture refills the slot
    // (including the same-cycle drain-and-refill case), otherwise the slot
    // drains when the ALU accepts and holds while back-pressured.
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Back-pressure counter sticks at its maximum instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload only moves on a capture, which keeps it stable under
    // back-pressure. A flush leaves stale data behind, hidden by out_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand1_q <= 32'd0;
            operand2_q <= 32'd0;
            opcode_q   <= EXE_ADD_OP;
            rd_addr_q  <= 5'd0;
        end else if (capture) begin
            operand1_q <= operand1_d;
            operand2_q <= operand2_d;
            opcode_q   <= in_alu_op;
            rd_addr_q  <= in_rd_addr;
        end
    end

    assign out_valid   = out_valid_q;
    assign operand1    = operand1_q;
    assign operand2    = operand2_q;
    assign opcode      = opcode_q;
    assign out_rd_addr = rd_addr_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. A transaction-level model tracks which
// instruction should sit in the stage and what its operands must be, and a
// compare process checks the DUT against it on every falling edge. Literal
// expectations worked out by hand pin the model for the key scenarios.
// Works with or without ID_EX_FORWARD_EN defined.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam logic [3:0] EXE_ADD_OP = 4'b0000;

   logic        clock = 1'b0;
   logic        rstN  = 1'b1;

   logic        inValid = 1'b0;
   logic        inReady;
   logic [31:0] inPc = '0, inRs1Data = '0, inRs2Data = '0, inImm = '0;
   logic [4:0]  inRs1Addr = '0, inRs2Addr = '0, inRdAddr = '0;
   logic [3:0]  inAluOp = '0;
   logic        inSrc1Pc = 1'b0, inSrc2Imm = 1'b0;
   logic        fwdMemWen = 1'b0, fwdWbWen = 1'b0;
   logic [4:0]  fwdMemRd = '0, fwdWbRd = '0;
   logic [31:0] fwdMemData = '0, fwdWbData = '0;
   logic        flush = 1'b0;
   logic        outValid;
   logic        outReady = 1'b0;
   logic [31:0] operand1, operand2;
   logic [3:0]  opcode;
   logic [4:0]  outRdAddr;
   logic [15:0] stallCnt;

   int assertCount = 0;
   int failCount   = 0;

   id_ex_stage dut (
      .clk          (clock),
      .rst_n        (rstN),
      .in_valid     (inValid),
      .in_ready     (inReady),
      .in_pc        (inPc),
      .in_rs1_data  (inRs1Data),
      .in_rs2_data  (inRs2Data),
      .in_imm       (inImm),
      .in_rs1_addr  (inRs1Addr),
      .in_rs2_addr  (inRs2Addr),
      .in_rd_addr   (inRdAddr),
      .in_alu_op    (inAluOp),
      .in_src1_pc   (inSrc1Pc),
      .in_src2_imm  (inSrc2Imm),
      .fwd_mem_wen  (fwdMemWen),
      .fwd_mem_rd   (fwdMemRd),
      .fwd_mem_data (fwdMemData),
      .fwd_wb_wen   (fwdWbWen),
      .fwd_wb_rd    (fwdWbRd),
      .fwd_wb_data  (fwdWbData),
      .flush        (flush),
      .out_valid    (outValid),
      .out_ready    (outReady),
      .operand1     (operand1),
      .operand2     (operand2),
      .opcode       (opcode),
      .out_rd_addr  (outRdAddr),
      .stall_cnt    (stallCnt)
   );

   // 10 ns clock
   always #5 clock = ~clock;

   // Hard stop in case something keeps the run from reaching its end.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check, reports each miss.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Present one decoded instruction on the input port.
   task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                                input logic [31:0] rs1Data, input logic [31:0] rs2Data,
                                input logic [31:0] imm, input logic [4:0] rs1Addr,
                                input logic [4:0] rs2Addr, input logic [4:0] rdAddr,
                                input logic [3:0] aluOp, input logic src1Pc,
                                input logic src2Imm);
      inValid   = valid;
      inPc      = pc;
      inRs1Data = rs1Data;
      inRs2Data = rs2Data;
      inImm     = imm;
      inRs1Addr = rs1Addr;
      inRs2Addr = rs2Addr;
      inRdAddr  = rdAddr;
      inAluOp   = aluOp;
      inSrc1Pc  = src1Pc;
      inSrc2Imm = src2Imm;
   endtask

   task automatic setForward(input logic memWen, input logic [4:0] memRd,
                             input logic [31:0] memData, input logic wbWen,
                             input logic [4:0] wbRd, input logic [31:0] wbData);
      fwdMemWen  = memWen;
      fwdMemRd   = memRd;
      fwdMemData = memData;
      fwdWbWen   = wbWen;
      fwdWbRd    = wbRd;
      fwdWbData  = wbData;
   endtask

   // Advance to just after the next rising edge; inputs change only here.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: which instruction occupies the stage and with what
   // resolved operands, plus an unbounded stall tally clipped at compare.
   // ---------------------------------------------------------------------
   logic        expValid = 1'b0;
   logic [31:0] expOp1   = '0;
   logic [31:0] expOp2   = '0;
   logic [3:0]  expOpc   = EXE_ADD_OP;
   logic [4:0]  expRd    = '0;
   int          stallRaw = 0;
   logic        modelAccept;

   // Value a register source should carry, given the bypass sources.
   function automatic logic [31:0] resolveReg(input logic [4:0] addr, input logic [31:0] regData);
`ifdef ID_EX_FORWARD_EN
      if (addr != 5'd0 && fwdMemWen && fwdMemRd == addr) return fwdMemData;
      if (addr != 5'd0 && fwdWbWen && fwdWbRd == addr) return fwdWbData;
`endif
      return regData;
   endfunction

   always @(posedge clock or negedge rstN) begin
      if (!rstN) begin
         expValid = 1'b0;
         expOp1   = '0;
         expOp2   = '0;
         expOpc   = EXE_ADD_OP;
         expRd    = '0;
         stallRaw = 0;
      end else begin
         modelAccept = inValid && !flush && (!expValid || outReady);
         if (expValid && !outReady) stallRaw++;
         if (modelAccept) begin
            expOp1   = inSrc1Pc  ? inPc  : resolveReg(inRs1Addr, inRs1Data);
            expOp2   = inSrc2Imm ? inImm : resolveReg(inRs2Addr, inRs2Data);
            expOpc   = inAluOp;
            expRd    = inRdAddr;
            expValid = 1'b1;
         end else if (flush || outReady) begin
            expValid = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      checkOutput("model out_valid", {31'd0, outValid}, {31'd0, expValid});
      checkOutput("model in_ready", {31'd0, inReady}, {31'd0, (!expValid || outReady)});
      checkOutput("model stall_cnt", {16'd0, stallCnt},
                  (stallRaw > 65535) ? 32'h0000FFFF : stallRaw);
      if (expValid) begin
         checkOutput("model operand1", operand1, expOp1);
         checkOutput("model operand2", operand2, expOp2);
         checkOutput("model opcode", {28'd0, opcode}, {28'd0, expOpc});
         checkOutput("model out_rd_addr", {27'd0, outRdAddr}, {27'd0, expRd});
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " out_valid"}, {31'd0, outValid}, 32'd0);
      checkOutput({tag, " operand1"}, operand1, 32'd0);
      checkOutput({tag, " operand2"}, operand2, 32'd0);
      checkOutput({tag, " opcode"}, {28'd0, opcode}, {28'd0, EXE_ADD_OP});
      checkOutput({tag, " out_rd_addr"}, {27'd0, outRdAddr}, 32'd0);
      checkOutput({tag, " stall_cnt"}, {16'd0, stallCnt}, 32'd0);
   endtask

   initial begin
      // Asynchronous reset, released between clock edges.
      #1 rstN = 1'b0;
      #11;
      checkResetValues("reset");
      rstN = 1'b1;
      outReady = 1'b1;
      tick();

      // Basic capture: register operands, one-cycle latency.
      applyStimulus(1'b1, 32'h0, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd1, EXE_ADD_OP, 1'b0, 1'b0);
      tick();
      checkOutput("basic out_valid", {31'd0, outValid}, 32'd1);
      checkOutput("basic operand1", operand1, 32'h5);
      checkOutput("basic operand2", operand2, 32'h7);

      // MEM and WB both target rs1: MEM must win (when forwarding enabled).
      setForward(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
      applyStimulus(1'b1, 32'h0, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd5, 4'd1, 1'b0, 1'b0);
      tick();
`ifdef ID_EX_FORWARD_EN
      checkOutput("fwd mem priority operand1", operand1, 32'hAA);
`else
      checkOutput("fwd disabled operand1", operand1, 32'h11);
`endif
      checkOutput("fwd operand2", operand2, 32'h22);
      checkOutput("fwd opcode", {28'd0, opcode}, 32'd1);
      checkOutput("fwd out_rd_addr", {27'd0, outRdAddr}, 32'd5);

      // Only WB matches.
      setForward(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
      tick();
`ifdef ID_EX_FORWARD_EN
      checkOutput("fwd wb operand1", operand1, 32'hBB);
`else
      checkOutput("fwd disabled wb operand1", operand1, 32'h11);
`endif

      // PC and immediate selects override register sources.
      applyStimulus(1'b1, 32'h1000, 32'h11, 32'h22, 32'h44, 5'd3, 5'd4, 5'd6, 4'd2, 1'b1, 1'b1);
      tick();
      checkOutput("select pc operand1", operand1, 32'h1000);
      checkOutput("select imm operand2", operand2, 32'h44);

      // x0 never forwards.
      setForward(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
      applyStimulus(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 4'd3, 1'b0, 1'b0);
      tick();
      checkOutput("x0 operand1", operand1, 32'h0);
      checkOutput("x0 operand2", operand2, 32'h0);
      setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Back-pressure: instruction A held for three cycles while B waits.
      applyStimulus(1'b1, 32'h0, 32'hA1, 32'hA2, 32'h0, 5'd8, 5'd9, 5'd10, 4'd4, 1'b0, 1'b0);
      tick();
      outReady = 1'b0;
      applyStimulus(1'b1, 32'h0, 32'hB1, 32'hB2, 32'h0, 5'd8, 5'd9, 5'd11, 4'd5, 1'b0, 1'b0);
      #1;
      checkOutput("stall in_ready low", {31'd0, inReady}, 32'd0);
      repeat (3) tick();
      checkOutput("stall operand1 held", operand1, 32'hA1);
      checkOutput("stall rd held", {27'd0, outRdAddr}, 32'd10);
      checkOutput("stall count three", {16'd0, stallCnt}, 32'd3);
      outReady = 1'b1;
      tick();
      checkOutput("release capture B", operand1, 32'hB1);
      applyStimulus(1'b1, 32'h0, 32'hC1, 32'hC2, 32'h0, 5'd8, 5'd9, 5'd12, 4'd6, 1'b0, 1'b0);
      tick();
      checkOutput("back-to-back capture C", operand1, 32'hC1);
      checkOutput("back-to-back out_valid", {31'd0, outValid}, 32'd1);

      // Flush while holding a stalled instruction, with a new one offered.
      outReady = 1'b0;
      applyStimulus(1'b1, 32'h0, 32'hD1, 32'hD2, 32'h0, 5'd8, 5'd9, 5'd13, 4'd7, 1'b0, 1'b0);
      tick();
      checkOutput("stalled keeps C", operand1, 32'hC1);
      flush = 1'b1;
      applyStimulus(1'b1, 32'h0, 32'hE1, 32'hE2, 32'h0, 5'd8, 5'd9, 5'd14, 4'd8, 1'b0, 1'b0);
      tick();
      checkOutput("flush out_valid", {31'd0, outValid}, 32'd0);
      flush = 1'b0;
      inValid = 1'b0;
      tick();
      checkOutput("after flush still empty", {31'd0, outValid}, 32'd0);

      // Long stall to saturate the counter, then asynchronous reset mid-stall.
      outReady = 1'b1;
      applyStimulus(1'b1, 32'h0, 32'hF1, 32'hF2, 32'h0, 5'd8, 5'd9, 5'd15, 4'd9, 1'b0, 1'b0);
      tick();
      inValid  = 1'b0;
      outReady = 1'b0;
      repeat (65540) tick();
      checkOutput("saturated stall_cnt", {16'd0, stallCnt}, 32'h0000FFFF);
      checkOutput("saturated holds F", operand1, 32'hF1);
      #3 rstN = 1'b0;
      #1;
      checkResetValues("async reset");

      // Instruction offered while reset is held across an edge: no capture.
      outReady = 1'b1;
      applyStimulus(1'b1, 32'h0, 32'h91, 32'h92, 32'h0, 5'd8, 5'd9, 5'd16, 4'd10, 1'b0, 1'b0);
      tick();
      checkOutput("no capture in reset", {31'd0, outValid}, 32'd0);
      #3 rstN = 1'b1;
      tick();
      checkOutput("post-reset capture valid", {31'd0, outValid}, 32'd1);
      checkOutput("post-reset capture operand1", operand1, 32'h91);
      checkOutput("post-reset capture operand2", operand2, 32'h92);
      inValid = 1'b0;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
